// File: rtl/peripheral_adder_responder.sv
// Operand/sum responder: adds accepted operand pairs and returns the sums in
// acceptance order through a small result FIFO, with delivery and carry counters.
module peripheral_adder_responder #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_WIDTH-1:0]         ip1,
    input  logic [DATA_WIDTH-1:0]         ip2,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH:0]           out,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic [CNT_WIDTH-1:0]          txn_count,
    output logic [CNT_WIDTH-1:0]          carry_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    logic [DATA_WIDTH:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [LVL_W-1:0]    level_next;
    logic [DATA_WIDTH:0] sum;
    logic                push;
    logic                pop;

    assign sum       = {1'b0, ip1} + {1'b0, ip2};
    assign out_valid = (level != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out       = mem[rd_ptr];

    always_comb begin
        level_next = level;
        case ({push, pop})
            2'b10:   level_next = level + LVL_W'(1);
            2'b01:   level_next = level - LVL_W'(1);
            default: level_next = level;
        endcase
    end

    // Storage is cleared on reset so the head reads zero until the first push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= sum;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level <= level_next;
        end
    end

    // Registered from the next level, so a pop while full reopens the input
    // one cycle later rather than bypassing in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready <= 1'b0;
        end else begin
            in_ready <= (level_next != LVL_FULL);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            txn_count   <= '0;
            carry_count <= '0;
        end else begin
            if (pop) begin
                txn_count <= txn_count + CNT_WIDTH'(1);
            end
            if (push && sum[DATA_WIDTH]) begin
                carry_count <= carry_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_peripheral_adder_responder.sv
// Directed bench for peripheral_adder_responder: reset, single sums, carry,
// backpressure, streaming and reset during operation.
module tb_peripheral_adder_responder;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] ip1;
    logic [7:0] ip2;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] out;
    logic [2:0] level;
    logic [15:0] txn_count;
    logic [15:0] carry_count;

    int checks;
    int failures;

    peripheral_adder_responder #(
        .DATA_WIDTH(8),
        .FIFO_DEPTH(4),
        .CNT_WIDTH (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ip1        (ip1),
        .ip2        (ip2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out        (out),
        .level      (level),
        .txn_count  (txn_count),
        .carry_count(carry_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b1; ip1 = 8'h5A; ip2 = 8'hA5; out_ready = 1'b1;
        repeat (3) tick();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (out !== 9'h000) begin failures++; $display("FAIL reset_out got=%h exp=000", out); end
        checks++; if (txn_count !== 16'd0 || carry_count !== 16'd0) begin failures++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", txn_count, carry_count); end
        in_valid = 1'b0;
        #4 rst = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%0b exp=1", in_ready); end
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL release_level got=%0d exp=0", level); end
        out_ready = 1'b0;
    endtask

    task automatic test_single();
        in_valid = 1'b1; ip1 = 8'h12; ip2 = 8'h34;
        tick();
        in_valid = 1'b0; ip1 = 'x; ip2 = 'x;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%0b exp=1", out_valid); end
        checks++; if (out !== 9'h046) begin failures++; $display("FAIL single_out got=%h exp=046", out); end
        checks++; if (level !== 3'd1) begin failures++; $display("FAIL single_level got=%0d exp=1", level); end
        tick();
        checks++; if (out !== 9'h046 || out_valid !== 1'b1) begin failures++; $display("FAIL single_hold got=%h/%0b exp=046/1", out, out_valid); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || level !== 3'd0) begin failures++; $display("FAIL single_pop got=%0b/%0d exp=0/0", out_valid, level); end
        checks++; if (txn_count !== 16'd1) begin failures++; $display("FAIL single_txn got=%0d exp=1", txn_count); end
    endtask

    task automatic test_carry();
        in_valid = 1'b1; ip1 = 8'hFF; ip2 = 8'h01;
        tick();
        in_valid = 1'b0;
        checks++; if (out !== 9'h100) begin failures++; $display("FAIL carry_out1 got=%h exp=100", out); end
        checks++; if (carry_count !== 16'd1) begin failures++; $display("FAIL carry_count1 got=%0d exp=1", carry_count); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid = 1'b1; ip1 = 8'hFF; ip2 = 8'hFF;
        tick();
        in_valid = 1'b0;
        checks++; if (out !== 9'h1FE) begin failures++; $display("FAIL carry_out2 got=%h exp=1FE", out); end
        checks++; if (carry_count !== 16'd2) begin failures++; $display("FAIL carry_count2 got=%0d exp=2", carry_count); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (txn_count !== 16'd3) begin failures++; $display("FAIL carry_txn got=%0d exp=3", txn_count); end
    endtask

    task automatic test_backpressure();
        logic [7:0] a_v [5];
        logic [7:0] b_v [5];
        logic [8:0] s_v [5];
        a_v[0] = 8'h10; b_v[0] = 8'h20; s_v[0] = 9'h030;
        a_v[1] = 8'h80; b_v[1] = 8'h80; s_v[1] = 9'h100;
        a_v[2] = 8'h7F; b_v[2] = 8'h01; s_v[2] = 9'h080;
        a_v[3] = 8'hC3; b_v[3] = 8'h3C; s_v[3] = 9'h0FF;
        a_v[4] = 8'hAA; b_v[4] = 8'h56; s_v[4] = 9'h100;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; ip1 = a_v[i]; ip2 = b_v[i];
            tick();
        end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready got=%0b exp=0", in_ready); end
        checks++; if (level !== 3'd4) begin failures++; $display("FAIL bp_full_level got=%0d exp=4", level); end
        checks++; if (carry_count !== 16'd3) begin failures++; $display("FAIL bp_carry_before_5th got=%0d exp=3", carry_count); end
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checks++; if (out_valid !== 1'b1 || out !== s_v[k]) begin failures++; $display("FAIL bp_order%0d got=%h/%0b exp=%h/1", k, out, out_valid, s_v[k]); end
            if (k == 0) begin
                checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_no_bypass got=%0b exp=0", in_ready); end
            end
            tick();
            if (k == 0) begin
                checks++; if (in_ready !== 1'b1 || level !== 3'd3) begin failures++; $display("FAIL bp_reopen got=%0b/%0d exp=1/3", in_ready, level); end
            end
            if (k == 1) begin
                in_valid = 1'b0;
                checks++; if (level !== 3'd3) begin failures++; $display("FAIL bp_push_pop_level got=%0d exp=3", level); end
            end
            if (k == 3) begin
                checks++; if (txn_count !== 16'd7) begin failures++; $display("FAIL bp_txn4 got=%0d exp=7", txn_count); end
            end
        end
        out_ready = 1'b0;
        checks++; if (level !== 3'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got=%0d/%0b exp=0/0", level, out_valid); end
        checks++; if (txn_count !== 16'd8 || carry_count !== 16'd4) begin failures++; $display("FAIL bp_counters got=%0d/%0d exp=8/4", txn_count, carry_count); end
    endtask

    task automatic test_streaming();
        logic [8:0] exp_sum;
        int         carries;
        carries = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1;
            ip1 = 8'($urandom_range(0, 255));
            ip2 = 8'($urandom_range(0, 255));
            exp_sum = {1'b0, ip1} + {1'b0, ip2};
            if (exp_sum[8]) carries++;
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_ready%0d got=%0b exp=1", i, in_ready); end
            tick();
            checks++; if (out !== exp_sum || out_valid !== 1'b1 || level !== 3'd1) begin failures++; $display("FAIL stream%0d got=%h/%0b/%0d exp=%h/1/1", i, out, out_valid, level, exp_sum); end
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL stream_end_level got=%0d exp=0", level); end
        checks++; if (txn_count !== 16'd40) begin failures++; $display("FAIL stream_txn got=%0d exp=40", txn_count); end
        checks++; if (carry_count !== 16'(4 + carries)) begin failures++; $display("FAIL stream_carry got=%0d exp=%0d", carry_count, 4 + carries); end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; ip1 = 8'(8'h90 + i); ip2 = 8'h90;
            tick();
        end
        checks++; if (level !== 3'd3) begin failures++; $display("FAIL midrst_level_before got=%0d exp=3", level); end
        #2 rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || level !== 3'd0) begin failures++; $display("FAIL midrst_async got=%0b/%0d exp=0/0", out_valid, level); end
        checks++; if (txn_count !== 16'd0 || carry_count !== 16'd0 || in_ready !== 1'b0) begin failures++; $display("FAIL midrst_clear got=%0d/%0d/%0b exp=0/0/0", txn_count, carry_count, in_ready); end
        in_valid = 1'b0;
        tick();
        #4 rst = 1'b1;
        tick();
        in_valid = 1'b1; ip1 = 8'h21; ip2 = 8'h43;
        tick();
        in_valid = 1'b0;
        checks++; if (out !== 9'h064 || level !== 3'd1) begin failures++; $display("FAIL midrst_first got=%h/%0d exp=064/1", out, level); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (level !== 3'd0 || txn_count !== 16'd1) begin failures++; $display("FAIL midrst_only_one got=%0d/%0d exp=0/1", level, txn_count); end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ip1 = '0; ip2 = '0;
        test_reset();
        test_single();
        test_carry();
        test_backpressure();
        test_streaming();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
